sdspi_host_arbiter: RTL and testbench

- Shares one sdspihost instance between two requesters.
  - Requester 0: the autotest sequencer.
  - Requester 1: the SD-SPI unit under test.
- Replaces the open-loop sdspi_ctrl_mux select with registered ownership, a guarded hand-over and a busy watchdog.
- Sits between both requesters and the host. All host command strobes, block address and write data pass through it, and it returns busy/data/error status per requester.

---
 rtl/sdspi_host_arbiter.sv | 117 +++++++++++
 tb/tb_sdspi_host_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdspi_host_arbiter.sv
// Arbiter that shares one SD-SPI host between the autotest sequencer (requester 0)
// and the SD-SPI unit under test (requester 1), with guarded hand-over and a busy watchdog.
module sdspi_host_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FFFFFF,
  parameter logic        RR_EN          = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  r_block,
  input  logic [1:0]  r_byte,
  input  logic [1:0]  r_multi_block,
  input  logic [1:0]  w_block,
  input  logic [1:0]  w_byte,
  input  logic [1:0]  host_rst_req,
  input  logic [31:0] block_addr_0,
  input  logic [31:0] block_addr_1,
  input  logic [7:0]  data_in_0,
  input  logic [7:0]  data_in_1,
  output logic [1:0]  busy,
  output logic [7:0]  data_out,
  output logic [1:0]  err,
  output logic [1:0]  crc_err,
  output logic        spi_r_block,
  output logic        spi_r_byte,
  output logic        spi_r_multi_block,
  output logic        spi_w_block,
  output logic        spi_w_byte,
  output logic        spi_rst,
  output logic [31:0] spi_block_addr,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic        spi_crc_err,
  input  logic [7:0]  spi_data_out,
  output logic [1:0]  owner,
  output logic        timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT0  = 2'd1;
  localparam logic [1:0] GRANT1  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        last_owner;
  logic [31:0] wd_cnt;
  logic        in_grant;
  logic        sel;
  logic        sel_req;
  logic        drive;
  logic        wd_fire;

  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign sel      = (state == GRANT1);
  assign sel_req  = req[sel];
  // Strobes are only passed while the owner still holds its request.
  assign drive    = in_grant && sel_req;
  assign wd_fire  = in_grant && spi_busy && (wd_cnt == TIMEOUT_CYCLES - 32'd1);

  assign spi_r_block       = drive && r_block[sel];
  assign spi_r_byte        = drive && r_byte[sel];
  assign spi_r_multi_block = drive && r_multi_block[sel];
  assign spi_w_block       = drive && w_block[sel];
  assign spi_w_byte        = drive && w_byte[sel];
  assign spi_rst           = wd_fire || (drive && host_rst_req[sel]);
  assign spi_block_addr    = in_grant ? (sel ? block_addr_1 : block_addr_0) : 32'd0;
  assign spi_data_in       = in_grant ? (sel ? data_in_1 : data_in_0) : 8'hFF;

  assign err      = gnt & {2{spi_err}};
  assign crc_err  = gnt & {2{spi_crc_err}};
  assign data_out = spi_data_out;
  assign owner    = state;
  assign timeout  = wd_fire;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    busy = 2'b11;
    if (in_grant) busy[sel] = spi_busy;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        case (req)
          2'b01:   next_state = GRANT0;
          2'b10:   next_state = GRANT1;
          2'b11:   next_state = (RR_EN && !last_owner) ? GRANT1 : GRANT0;
          default: next_state = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (wd_fire || (!sel_req && !spi_busy)) next_state = RELEASE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      last_owner <= 1'b1;
      wd_cnt     <= 32'd0;
    end else begin
      state <= next_state;
      gnt   <= {next_state == GRANT1, next_state == GRANT0};
      if (state == IDLE && next_state != IDLE) last_owner <= (next_state == GRANT1);
      wd_cnt <= (in_grant && spi_busy && !wd_fire) ? wd_cnt + 32'd1 : 32'd0;
    end
  end

endmodule

// File: tb/tb_sdspi_host_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share one stimulus stream
// and are each compared against a behavioural ownership model.
module tb_sdspi_host_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  busy;
    logic [1:0]  err;
    logic [1:0]  crc;
    logic [1:0]  owner;
    logic        timeout;
    logic [5:0]  strb;
    logic [31:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, r_block, r_byte, r_multi_block, w_block, w_byte, host_rst_req;
  logic [31:0] block_addr_0, block_addr_1;
  logic [7:0]  data_in_0, data_in_1, spi_data_out;
  logic        spi_busy, spi_err, spi_crc_err;

  logic [1:0]  a_gnt, a_busy, a_err, a_crc, a_owner, b_gnt, b_busy, b_err, b_crc, b_owner;
  logic [7:0]  a_dout, a_din, b_dout, b_din;
  logic [31:0] a_addr, b_addr;
  logic        a_rb, a_ry, a_rm, a_wb, a_wy, a_rs, a_to;
  logic        b_rb, b_ry, b_rm, b_wb, b_wy, b_rs, b_to;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Model state per instance: current owner (-1 = none), release gap pending, busy run, last owner.
  int m_own[2];
  int m_cool[2];
  int m_run[2];
  int m_last[2];

  always #5 clk = ~clk;

  sdspi_host_arbiter #(.TIMEOUT_CYCLES(32'(TO)), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .gnt(a_gnt),
    .r_block(r_block), .r_byte(r_byte), .r_multi_block(r_multi_block),
    .w_block(w_block), .w_byte(w_byte), .host_rst_req(host_rst_req),
    .block_addr_0(block_addr_0), .block_addr_1(block_addr_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .busy(a_busy), .data_out(a_dout), .err(a_err), .crc_err(a_crc),
    .spi_r_block(a_rb), .spi_r_byte(a_ry), .spi_r_multi_block(a_rm),
    .spi_w_block(a_wb), .spi_w_byte(a_wy), .spi_rst(a_rs),
    .spi_block_addr(a_addr), .spi_data_in(a_din),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_crc_err(spi_crc_err),
    .spi_data_out(spi_data_out), .owner(a_owner), .timeout(a_to)
  );

  sdspi_host_arbiter #(.TIMEOUT_CYCLES(32'(TO)), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req(req), .gnt(b_gnt),
    .r_block(r_block), .r_byte(r_byte), .r_multi_block(r_multi_block),
    .w_block(w_block), .w_byte(w_byte), .host_rst_req(host_rst_req),
    .block_addr_0(block_addr_0), .block_addr_1(block_addr_1),
    .data_in_0(data_in_0), .data_in_1(data_in_1),
    .busy(b_busy), .data_out(b_dout), .err(b_err), .crc_err(b_crc),
    .spi_r_block(b_rb), .spi_r_byte(b_ry), .spi_r_multi_block(b_rm),
    .spi_w_block(b_wb), .spi_w_byte(b_wy), .spi_rst(b_rs),
    .spi_block_addr(b_addr), .spi_data_in(b_din),
    .spi_busy(spi_busy), .spi_err(spi_err), .spi_crc_err(spi_crc_err),
    .spi_data_out(spi_data_out), .owner(b_owner), .timeout(b_to)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out(input int k);
    exp_t e;
    int   x;
    e.gnt = 2'b00; e.busy = 2'b11; e.err = 2'b00; e.crc = 2'b00;
    e.timeout = 1'b0; e.strb = 6'd0; e.addr = 32'd0; e.din = 8'hFF;
    e.dout = spi_data_out;
    if (m_own[k] >= 0)      e.owner = 2'(m_own[k] + 1);
    else if (m_cool[k] > 0) e.owner = 2'd3;
    else                    e.owner = 2'd0;
    if (m_own[k] >= 0) begin
      x = m_own[k];
      e.gnt[x]  = 1'b1;
      e.busy[x] = spi_busy;
      e.err[x]  = spi_err;
      e.crc[x]  = spi_crc_err;
      e.timeout = spi_busy && (m_run[k] == TO - 1);
      if (req[x]) e.strb = {r_block[x], r_byte[x], r_multi_block[x], w_block[x], w_byte[x], host_rst_req[x]};
      e.strb[0] = e.strb[0] | e.timeout;
      e.addr = (x == 1) ? block_addr_1 : block_addr_0;
      e.din  = (x == 1) ? data_in_1 : data_in_0;
    end
    return e;
  endfunction

  task automatic model_step(input int k, input bit rr);
    int  x;
    int  p;
    bit  fire;
    if (rst) begin
      m_own[k] = -1; m_cool[k] = 0; m_run[k] = 0; m_last[k] = 1;
    end else if (m_own[k] >= 0) begin
      x = m_own[k];
      fire = spi_busy && (m_run[k] == TO - 1);
      if (fire || (!req[x] && !spi_busy)) begin
        m_own[k] = -1; m_cool[k] = 1; m_run[k] = 0;
      end else begin
        m_run[k] = spi_busy ? m_run[k] + 1 : 0;
      end
    end else if (m_cool[k] > 0) begin
      m_cool[k] = 0;
    end else begin
      p = -1;
      if (req == 2'b01)      p = 0;
      else if (req == 2'b10) p = 1;
      else if (req == 2'b11) p = rr ? 1 - m_last[k] : 0;
      if (p >= 0) begin
        m_own[k] = p; m_last[k] = p; m_run[k] = 0;
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
  endtask

  task automatic push_exp();
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
  endtask

  task automatic cyc(input logic r, input logic [1:0] rq, input logic bz,
                     input logic [1:0] rb, input logic [1:0] wy, input logic [1:0] wb, input int n);
    for (int i = 0; i < n; i++) begin
      edge_step();
      rst = r; req = rq; spi_busy = bz; r_block = rb; w_byte = wy; w_block = wb;
      push_exp();
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input exp_t a);
    check({tag, ".gnt"},     32'(a.gnt),     32'(e.gnt));
    check({tag, ".owner"},   32'(a.owner),   32'(e.owner));
    check({tag, ".busy"},    32'(a.busy),    32'(e.busy));
    check({tag, ".timeout"}, 32'(a.timeout), 32'(e.timeout));
    check({tag, ".strobes"}, 32'(a.strb),    32'(e.strb));
    check({tag, ".addr"},    a.addr,         e.addr);
    check({tag, ".din"},     32'(a.din),     32'(e.din));
    check({tag, ".dout"},    32'(a.dout),    32'(e.dout));
    check({tag, ".errs"},    32'({a.err, a.crc}), 32'({e.err, e.crc}));
  endtask

  always @(negedge clk) begin
    exp_t ea;
    exp_t eb;
    if (q_a.size() > 0 && q_b.size() > 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      compare("rr", ea, {a_gnt, a_busy, a_err, a_crc, a_owner, a_to,
                         {a_rb, a_ry, a_rm, a_wb, a_wy, a_rs}, a_addr, a_din, a_dout});
      compare("fp", eb, {b_gnt, b_busy, b_err, b_crc, b_owner, b_to,
                         {b_rb, b_ry, b_rm, b_wb, b_wy, b_rs}, b_addr, b_din, b_dout});
    end
  end

  initial begin
    int mode;
    rst = 1'b1; req = 2'b00; spi_busy = 1'b0; spi_err = 1'b0; spi_crc_err = 1'b0;
    r_block = 2'b00; r_byte = 2'b00; r_multi_block = 2'b00; w_block = 2'b00; w_byte = 2'b00;
    host_rst_req = 2'b00; block_addr_0 = 32'h00100000; block_addr_1 = 32'hABCD0001;
    data_in_0 = 8'h5A; data_in_1 = 8'hC3; spi_data_out = 8'h3C;
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1; m_cool[k] = 0; m_run[k] = 0; m_last[k] = 1;
    end

    cyc(1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2);
    // Single request, then a read-block strobe from requester 0.
    cyc(1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    cyc(1'b0, 2'b01, 1'b0, 2'b01, 2'b00, 2'b00, 2);
    cyc(1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2);
    // Owner 0 drops: release, idle, then requester 1 takes over.
    cyc(1'b0, 2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 4);
    cyc(1'b0, 2'b10, 1'b1, 2'b00, 2'b10, 2'b00, 3);
    cyc(1'b0, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 2);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 3);
    // Stuck busy under grant 0 until the watchdog fires.
    cyc(1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 13);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 3);
    // Reset while requester 1 owns with a write-block strobe, then contention.
    cyc(1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 3);
    cyc(1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 1);
    cyc(1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 4);
    // Continuous contention with short transactions: fixed priority never serves requester 1.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2);
      cyc(1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 1);
    end

    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      edge_step();
      if ($urandom_range(0, 39) == 0) mode = int'($urandom_range(0, 2));
      spi_busy = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      rst = ($urandom_range(0, 299) == 0);
      r_block = 2'($urandom); r_byte = 2'($urandom); r_multi_block = 2'($urandom);
      w_block = 2'($urandom); w_byte = 2'($urandom); host_rst_req = 2'($urandom);
      block_addr_0 = $urandom; block_addr_1 = $urandom;
      data_in_0 = 8'($urandom); data_in_1 = 8'($urandom); spi_data_out = 8'($urandom);
      spi_err = 1'($urandom); spi_crc_err = 1'($urandom);
      push_exp();
    end

    repeat (2) @(posedge clk);
    check("drain", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
